// File: rtl/recfn_to_fn_seq.sv
// Sequential recoded-to-IEEE float converter: one result per request, with subnormals
// denormalised one bit per cycle in a shift register.
module recfn_to_fn_seq #(
   parameter int expWidth    = 8,
   parameter int sigWidth    = 24,
   parameter int inputWidth  = expWidth + sigWidth + 1,
   parameter int outputWidth = expWidth + sigWidth
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic [inputWidth-1:0]  in_,
   output logic [outputWidth-1:0] out,
   output logic                   done,
   output logic                   busy
);

   localparam int cntWidth = $clog2(sigWidth);
   localparam logic [expWidth:0] minNormExp = (expWidth+1)'((1 << (expWidth-1)) + 2);
   localparam logic [expWidth:0] maxShift   = (expWidth+1)'(sigWidth - 1);

   typedef enum logic [1:0] {IDLE, DECODE, SHIFT, DONE} stateType;

   stateType               state, stateNext;
   logic [inputWidth-1:0]  inReg, inRegNext;
   logic [outputWidth-1:0] outNext;
   logic [sigWidth-2:0]    shiftReg, shiftNext;
   logic [cntWidth-1:0]    count, countNext;

   logic                sign;
   logic [expWidth:0]   expIn;
   logic [sigWidth-2:0] fractIn;
   logic                isZero, isInf, isNaN, isSub;
   logic [expWidth:0]   subDist, shiftAmt;

   assign sign    = inReg[inputWidth-1];
   assign expIn   = inReg[inputWidth-2 -: expWidth+1];
   assign fractIn = inReg[sigWidth-2:0];

   assign isZero = (expIn[expWidth -: 3] == 3'b000);
   assign isInf  = (expIn[expWidth -: 3] == 3'b110);
   assign isNaN  = (expIn[expWidth -: 3] == 3'b111);
   assign isSub  = !isZero && (expIn < minNormExp);

   // Distance below the smallest normal exponent; only meaningful when isSub.
   assign subDist  = minNormExp - (expWidth+1)'(1) - expIn;
   assign shiftAmt = (subDist > maxShift) ? maxShift : subDist;

   assign done = (state == DONE);
   assign busy = (state != IDLE);

   always_comb begin
      // NOTE: every target gets its hold value first so no path leaves one unassigned (no latches).
      stateNext = state;
      inRegNext = inReg;
      outNext   = out;
      shiftNext = shiftReg;
      countNext = count;
      unique case (state)
         IDLE: begin
            if (go) begin
               inRegNext = in_;
               stateNext = DECODE;
            end
         end
         DECODE: begin
            stateNext = DONE;
            if (isZero) begin
               outNext = {sign, {expWidth{1'b0}}, {(sigWidth-1){1'b0}}};
            end else if (isInf) begin
               outNext = {sign, {expWidth{1'b1}}, {(sigWidth-1){1'b0}}};
            end else if (isNaN) begin
               outNext = {sign, {expWidth{1'b1}}, fractIn};
            end else if (isSub) begin
               shiftNext = {1'b1, fractIn[sigWidth-2:1]};
               countNext = cntWidth'(shiftAmt);
               stateNext = SHIFT;
            end else begin
               outNext = {sign, expWidth'(expIn - minNormExp + (expWidth+1)'(1)), fractIn};
            end
         end
         SHIFT: begin
            if (count != '0) begin
               shiftNext = shiftReg >> 1;
               countNext = count - cntWidth'(1);
            end else begin
               outNext   = {sign, {expWidth{1'b0}}, shiftReg};
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         inReg    <= '0;
         out      <= '0;
         shiftReg <= '0;
         count    <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         state    <= stateNext;
         inReg    <= inRegNext;
         out      <= outNext;
         shiftReg <= shiftNext;
         count    <= countNext;
      end
   end

endmodule

// File: tb/tb_recfn_to_fn_seq.sv
// Self-checking bench: IEEE values are recoded by a behavioural model, converted by the
// DUT, and compared bit-for-bit along with latency, done pulse shape and out holding.
module tb_recfn_to_fn_seq;

   localparam int EW = 8;
   localparam int SW = 24;
   localparam int IW = EW + SW + 1;
   localparam int OW = EW + SW;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          go    = 1'b0;
   logic [IW-1:0] in_   = '0;
   logic [OW-1:0] out;
   logic          done;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;
   logic [OW-1:0] lastOut = '0;

   recfn_to_fn_seq #(.expWidth(EW), .sigWidth(SW), .inputWidth(IW), .outputWidth(OW)) dut (
      .clk  (clk),
      .reset(reset),
      .go   (go),
      .in_  (in_),
      .out  (out),
      .done (done),
      .busy (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Leading-zero count of a subnormal fraction: how far it sits below the hidden-bit position.
   function automatic int fracLz(input logic [31:0] f);
      int p = -1;
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      return 22 - p;
   endfunction

   // IEEE single -> recoded form; specials/zero get arbitrary low exponent bits.
   function automatic logic [32:0] toRec(input logic [31:0] f, input logic [5:0] junk);
      logic [8:0]  e;
      logic [22:0] fr;
      fr = f[22:0];
      if (f[30:23] == 8'hFF)
         e = {((fr != 0) ? 3'b111 : 3'b110), junk};
      else if (f[30:23] == 8'h00 && fr == 0)
         e = {3'b000, junk};
      else if (f[30:23] == 8'h00) begin
         e  = 9'(129 - fracLz(f));
         fr = 23'(f[22:0] << (fracLz(f) + 1));
      end else
         e = 9'(int'(f[30:23]) + 129);
      return {f[31], e, fr};
   endfunction

   function automatic int expLat(input logic [31:0] f);
      if (f[30:23] == 8'h00 && f[22:0] != 0) return 3 + fracLz(f);
      return 2;
   endfunction

   // Called just after the edge that sampled go; ends at a negedge with the DUT idle.
   task automatic waitDone(input logic [OW-1:0] want, input int wantLat,
                           input logic [IW-1:0] laterIn, input string tag);
      int   lat  = 1;
      logic seen = 1'b0;
      in_ = IW'({$urandom, $urandom});
      while (!seen && lat < 64) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            check({tag, " busy"}, 64'(busy), 64'(1));
            check({tag, " out held"}, 64'(out), 64'(lastOut));
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) in_ = laterIn;
         end
      end
      check({tag, " done seen"}, 64'(seen), 64'(1));
      if (seen) begin
         check({tag, " out"}, 64'(out), 64'(want));
         check({tag, " latency"}, 64'(lat), 64'(wantLat));
         lastOut = want;
      end
      @(negedge clk);
      check({tag, " done width"}, 64'(done), 64'(0));
      check({tag, " idle after"}, 64'(busy), 64'(0));
   endtask

   task automatic runConv(input logic [IW-1:0] rec, input logic [OW-1:0] want,
                          input int wantLat, input string tag);
      in_ = rec;
      go  = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      waitDone(want, wantLat, IW'({$urandom, $urandom}), tag);
   endtask

   initial begin
      logic [31:0] f;
      logic        lowSeen;
      int          r;

      // Model pins against hand-derived encodings.
      check("model 1.0", 64'(toRec(32'h3F80_0000, 6'h0)), 64'h0_8000_0000);
      check("model minsub", 64'(toRec(32'h0000_0001, 6'h0)), 64'h0_3580_0000);
      check("model minsub lat", 64'(expLat(32'h0000_0001)), 64'd25);

      // Reset state.
      #1 reset = 1'b0;
      #1;
      check("reset out", 64'(out), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Directed values and boundaries.
      runConv(33'h0_8000_0000, 32'h3F80_0000, 2, "one");
      runConv(33'h0_3580_0000, 32'h0000_0001, 25, "minsub");
      runConv(33'h0_C000_0000, 32'h7F80_0000, 2, "inf");
      runConv(33'h0_E040_0000, 32'h7FC0_0000, 2, "nan");
      runConv(33'h1_0000_0000, 32'h8000_0000, 2, "negzero");
      runConv({1'b1, 9'h03F, 23'h7FFFFF}, 32'h8000_0000, 2, "zero junk");
      runConv({1'b0, 9'd64, 23'h7FFFFF}, 32'h0000_0000, 26, "clamp");
      runConv({1'b0, 9'd129, 23'h0}, 32'h0040_0000, 3, "maxsub");
      runConv({1'b0, 9'd130, 23'h123456}, 32'h0092_3456, 2, "minnorm");

      // go held high; in_ changes mid-conversion; second start only from IDLE.
      in_ = 33'h0_3580_0000;
      go  = 1'b1;
      @(posedge clk);
      #1;
      waitDone(32'h0000_0001, 25, 33'h0_8000_0000, "held first");
      @(posedge clk);
      #1;
      go = 1'b0;
      waitDone(32'h3F80_0000, 2, IW'({$urandom, $urandom}), "held second");

      // Reset abort during SHIFT.
      in_ = 33'h0_3580_0000;
      go  = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort out", 64'(out), 64'(0));
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      lastOut = '0;
      lowSeen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done) lowSeen = 1'b1;
      end
      check("abort no done", 64'(lowSeen), 64'(0));
      reset = 1'b1;
      @(negedge clk);
      runConv(33'h0_C000_0000, 32'h7F80_0000, 2, "after abort");

      // Random sweep: out must reproduce the original IEEE bits.
      for (int n = 0; n < 10000; n++) begin
         r = $urandom_range(0, 9);
         f = $urandom;
         case (r)
            0: f = {f[31], 31'h0};
            1: f = {f[31], 8'hFF, 23'h0};
            2: f = {f[31], 8'hFF, ((f[22:0] == 0) ? 23'h1 : f[22:0])};
            3: begin
               f[30:23] = 8'h00;
               f[22:0]  = f[22:0] >> $urandom_range(0, 22);
               if (f[22:0] == 0) f[22:0] = 23'h1;
            end
            default: if (f[30:23] == 8'hFF || f[30:23] == 8'h00) f[30:23] = 8'h7E;
         endcase
         runConv(toRec(f, 6'($urandom)), f, expLat(f), "sweep");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
